// File: rtl/vc_arbiter.sv
// ---------------------------------------------------------------------------
// vc_arbiter
//
// Drains two upstream virtual-channel FIFOs (VC0, VC1) one word per cycle and
// routes each word to one of two downstream FIFOs (D0, D1).  The destination
// is chosen by bit [DATA_WIDTH-2] of the word itself (0 -> D0, 1 -> D1).
// A pop in cycle N produces a push in cycle N+2: the upstream FIFO returns its
// data one cycle after the pop, and the push is registered one cycle later.
//
// Optional feature (compile-time macro): ARB_RR_EN
//   undefined : VC0 has strict priority over VC1.
//   defined   : round-robin between the two VCs when both hold data.
//
// Ports
//   clk                            single clock, rising edge
//   reset                          asynchronous reset, active low
//   init                           synchronous soft-init, active low
//   vc0_empty, vc1_empty           upstream FIFO empty flags
//   vc0_data, vc1_data             upstream registered read data
//   d0_almost_full, d1_almost_full downstream backpressure
//   vc0_pop, vc1_pop               upstream read enables (combinational)
//   d0_push, d1_push               downstream write enables (registered)
//   d0_data, d1_data               downstream write data (registered)
//   state                          INIT=0, IDLE=1, ACTIVE=2, STALL=3
//   fwd_count                      8-bit wrapping count of pushed words
// ---------------------------------------------------------------------------
module vc_arbiter #(
  parameter int DATA_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  vc0_empty,
  input  logic                  vc1_empty,
  input  logic [DATA_WIDTH-1:0] vc0_data,
  input  logic [DATA_WIDTH-1:0] vc1_data,
  input  logic                  d0_almost_full,
  input  logic                  d1_almost_full,
  output logic                  vc0_pop,
  output logic                  vc1_pop,
  output logic                  d0_push,
  output logic                  d1_push,
  output logic [DATA_WIDTH-1:0] d0_data,
  output logic [DATA_WIDTH-1:0] d1_data,
  output logic [1:0]            state,
  output logic [7:0]            fwd_count
);

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2,
    STALL  = 2'd3
  } state_t;

  state_t                state_q;
  logic                  valid_q;
  logic                  src_q;
  logic                  stall;
  logic                  can_pop;
  logic                  grant_vc1;
  logic                  pop_any;
  logic [DATA_WIDTH-1:0] fwd_word;

  assign stall = d0_almost_full | d1_almost_full;

  // A pop is only allowed from ACTIVE with no backpressure and init released.
  // Requiring at least one non-empty VC here, together with grant_vc1 always
  // pointing at a non-empty VC, guarantees we never pop an empty FIFO.
  assign can_pop = (state_q == ACTIVE) && !stall && init && !(vc0_empty && vc1_empty);

`ifdef ARB_RR_EN
  // rr_vc1 names the VC that wins the next tie (0 = VC0). It starts at VC0 so
  // the first contested grant after reset goes to VC0, then flips to the VC
  // that was not granted on every pop, contested or not.
  logic rr_vc1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_vc1 <= 1'b0;
    end else if (!init) begin
      rr_vc1 <= 1'b0;
    end else if (pop_any) begin
      rr_vc1 <= vc0_pop;
    end
  end

  assign grant_vc1 = (!vc0_empty && !vc1_empty) ? rr_vc1 : vc0_empty;
`else
  // Strict priority: VC1 only gets a turn when VC0 has nothing to offer.
  assign grant_vc1 = vc0_empty;
`endif

  assign vc0_pop = can_pop && !grant_vc1;
  assign vc1_pop = can_pop &&  grant_vc1;
  assign pop_any = vc0_pop | vc1_pop;

  // The FSM state is recomputed every edge from the current inputs. valid_q
  // and src_q remember that a word was popped last cycle and from which VC,
  // since the FIFO only presents that word one cycle after the pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      valid_q <= 1'b0;
      src_q   <= 1'b0;
    end else if (!init) begin
      state_q <= INIT;
      valid_q <= 1'b0;
      src_q   <= 1'b0;
    end else begin
      valid_q <= pop_any;
      if (pop_any) begin
        src_q <= vc1_pop;
      end
      if (stall) begin
        state_q <= STALL;
      end else if (vc0_empty && vc1_empty) begin
        state_q <= IDLE;
      end else begin
        state_q <= ACTIVE;
      end
    end
  end

  assign state    = state_q;
  assign fwd_word = src_q ? vc1_data : vc0_data;

  // Downstream side. A word already popped (valid_q=1) is always pushed, even
  // when init drops at this edge, so init clears the data registers first and
  // the pending push then overrides the selected one. The unselected data
  // register otherwise keeps its value. fwd_count counts cycles on which a
  // push was visible, so it trails the push by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d0_push   <= 1'b0;
      d1_push   <= 1'b0;
      d0_data   <= '0;
      d1_data   <= '0;
      fwd_count <= '0;
    end else begin
      d0_push <= 1'b0;
      d1_push <= 1'b0;
      if (!init) begin
        d0_data   <= '0;
        d1_data   <= '0;
        fwd_count <= '0;
      end else if (d0_push || d1_push) begin
        fwd_count <= fwd_count + 8'd1;
      end
      if (valid_q) begin
        if (fwd_word[DATA_WIDTH-2]) begin
          d1_push <= 1'b1;
          d1_data <= fwd_word;
        end else begin
          d0_push <= 1'b1;
          d0_data <= fwd_word;
        end
      end
    end
  end

endmodule
